// File: rtl/e203_exu_fpu_fmis_sched_if.sv
// Handshake bundle between dispatch, the FMIS misc-op unit and writeback.
// master = the issue sequencer, slave = its environment.
interface e203_exu_fpu_fmis_sched_if #(
  parameter int XLEN   = 32,
  parameter int INFO_W = 8,
  parameter int ITAG_W = 4
) ();
  logic              sch_i_valid;
  logic              sch_i_ready;
  logic [XLEN-1:0]   sch_i_rs1;
  logic [XLEN-1:0]   sch_i_rs2;
  logic [XLEN-1:0]   sch_i_imm;
  logic [INFO_W-1:0] sch_i_info;
  logic [ITAG_W-1:0] sch_i_itag;
  logic              flush_pulse;

  logic              fmis_i_valid;
  logic              fmis_i_ready;
  logic [XLEN-1:0]   fmis_i_rs1;
  logic [XLEN-1:0]   fmis_i_rs2;
  logic [XLEN-1:0]   fmis_i_imm;
  logic [INFO_W-1:0] fmis_i_info;
  logic [ITAG_W-1:0] fmis_i_itag;

  logic              fmis_o_valid;
  logic              fmis_o_ready;
  logic [XLEN-1:0]   fmis_o_wbck_wdat;
  logic              fmis_o_wbck_err;

  logic              sch_o_valid;
  logic              sch_o_ready;
  logic [XLEN-1:0]   sch_o_wdat;
  logic              sch_o_err;
  logic [ITAG_W-1:0] sch_o_itag;
  logic              sch_busy;

  modport master (
    input  sch_i_valid, sch_i_rs1, sch_i_rs2, sch_i_imm, sch_i_info, sch_i_itag, flush_pulse,
    input  fmis_i_ready, fmis_o_valid, fmis_o_wbck_wdat, fmis_o_wbck_err, sch_o_ready,
    output sch_i_ready, fmis_i_valid, fmis_i_rs1, fmis_i_rs2, fmis_i_imm, fmis_i_info, fmis_i_itag,
    output fmis_o_ready, sch_o_valid, sch_o_wdat, sch_o_err, sch_o_itag, sch_busy
  );

  modport slave (
    output sch_i_valid, sch_i_rs1, sch_i_rs2, sch_i_imm, sch_i_info, sch_i_itag, flush_pulse,
    output fmis_i_ready, fmis_o_valid, fmis_o_wbck_wdat, fmis_o_wbck_err, sch_o_ready,
    input  sch_i_ready, fmis_i_valid, fmis_i_rs1, fmis_i_rs2, fmis_i_imm, fmis_i_info, fmis_i_itag,
    input  fmis_o_ready, sch_o_valid, sch_o_wdat, sch_o_err, sch_o_itag, sch_busy
  );
endinterface

// File: rtl/e203_exu_fpu_fmis_sched.sv
// Single-outstanding issue sequencer for the FMIS misc-op datapath: latches one op,
// holds it stable for FMIS, registers the result for writeback and drains on flush.
module e203_exu_fpu_fmis_sched #(
  parameter int XLEN   = 32,
  parameter int INFO_W = 8,
  parameter int ITAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  e203_exu_fpu_fmis_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]   rs1_q, rs2_q, imm_q, wdat_q;
  logic [INFO_W-1:0] info_q;
  logic [ITAG_W-1:0] itag_q;
  logic              err_q;

  logic accept;
  logic capture;

  // Gating with rst_n keeps the accept low while reset is held, since IDLE alone would raise it.
  assign accept  = (state_q == IDLE) & rst_n & ~bus.flush_pulse & bus.sch_i_valid;
  assign capture = ~bus.flush_pulse & bus.fmis_o_valid &
                   (((state_q == ISSUE) & bus.fmis_i_ready) | (state_q == WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.fmis_i_ready) begin
          if (bus.fmis_o_valid)     state_d = bus.flush_pulse ? IDLE : RESP;
          else                      state_d = bus.flush_pulse ? DRAIN : WAIT;
        end else if (bus.flush_pulse) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.fmis_o_valid)       state_d = bus.flush_pulse ? IDLE : RESP;
        else if (bus.flush_pulse)   state_d = DRAIN;
      end
      RESP: begin
        if (bus.flush_pulse | bus.sch_o_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (bus.fmis_o_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.sch_i_ready  = (state_q == IDLE) & rst_n & ~bus.flush_pulse;
    bus.fmis_i_valid = (state_q == ISSUE);
    bus.fmis_o_ready = (state_q == ISSUE) | (state_q == WAIT) | (state_q == DRAIN);
    bus.sch_o_valid  = (state_q == RESP);
    bus.sch_busy     = (state_q != IDLE);
  end

  // Operand/info/tag registers only move on accept, so FMIS sees them stable IDLE to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      info_q <= '0;
      itag_q <= '0;
    end else if (accept) begin
      rs1_q  <= bus.sch_i_rs1;
      rs2_q  <= bus.sch_i_rs2;
      imm_q  <= bus.sch_i_imm;
      info_q <= bus.sch_i_info;
      itag_q <= bus.sch_i_itag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdat_q <= '0;
      err_q  <= 1'b0;
    end else if (capture) begin
      wdat_q <= bus.fmis_o_wbck_wdat;
      err_q  <= bus.fmis_o_wbck_err;
    end
  end

  assign bus.fmis_i_rs1  = rs1_q;
  assign bus.fmis_i_rs2  = rs2_q;
  assign bus.fmis_i_imm  = imm_q;
  assign bus.fmis_i_info = info_q;
  assign bus.fmis_i_itag = itag_q;
  assign bus.sch_o_wdat  = wdat_q;
  assign bus.sch_o_err   = err_q;
  assign bus.sch_o_itag  = itag_q;

endmodule

// File: tb/tb_e203_exu_fpu_fmis_sched.sv
// Randomized bench for the FMIS issue sequencer against a flag-level transaction model.
module tb_e203_exu_fpu_fmis_sched;

  localparam int XLEN   = 32;
  localparam int INFO_W = 8;
  localparam int ITAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  e203_exu_fpu_fmis_sched_if #(.XLEN(XLEN), .INFO_W(INFO_W), .ITAG_W(ITAG_W)) bus ();

  e203_exu_fpu_fmis_sched #(.XLEN(XLEN), .INFO_W(INFO_W), .ITAG_W(ITAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: an op is either being offered to FMIS, owed by FMIS (maybe to be discarded),
  // or held as a result for writeback.
  bit                m_req, m_owed, m_disc, m_res;
  logic [XLEN-1:0]   op_rs1, op_rs2, op_imm, res_wdat;
  logic [INFO_W-1:0] op_info;
  logic [ITAG_W-1:0] op_itag;
  logic              res_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_owed = 0; m_disc = 0; m_res = 0;
    op_rs1 = '0; op_rs2 = '0; op_imm = '0; op_info = '0; op_itag = '0;
    res_wdat = '0; res_err = 1'b0;
  endtask

  task automatic drive_random();
    bus.sch_i_valid      = ($urandom_range(0, 9) < 6);
    bus.sch_i_rs1        = $urandom;
    bus.sch_i_rs2        = $urandom;
    bus.sch_i_imm        = $urandom;
    bus.sch_i_info       = INFO_W'(1) << $urandom_range(0, INFO_W - 1);
    bus.sch_i_itag       = ITAG_W'($urandom);
    bus.flush_pulse      = ($urandom_range(0, 9) == 0);
    bus.fmis_i_ready     = ($urandom_range(0, 1) == 1);
    bus.fmis_o_valid     = ($urandom_range(0, 9) < 4);
    bus.fmis_o_wbck_wdat = $urandom;
    bus.fmis_o_wbck_err  = ($urandom_range(0, 7) == 0);
    bus.sch_o_ready      = ($urandom_range(0, 1) == 1);
  endtask

  task automatic check_all_zero();
    chk("rst sch_i_ready", bus.sch_i_ready, 0);
    chk("rst fmis_i_valid", bus.fmis_i_valid, 0);
    chk("rst fmis_o_ready", bus.fmis_o_ready, 0);
    chk("rst sch_o_valid", bus.sch_o_valid, 0);
    chk("rst sch_busy", bus.sch_busy, 0);
    chk("rst fmis_i_rs1", bus.fmis_i_rs1, 0);
    chk("rst fmis_i_info", bus.fmis_i_info, 0);
    chk("rst fmis_i_itag", bus.fmis_i_itag, 0);
    chk("rst sch_o_wdat", bus.sch_o_wdat, 0);
    chk("rst sch_o_err", bus.sch_o_err, 0);
  endtask

  task automatic check_outputs();
    bit busy;
    busy = m_req | m_owed | m_res;
    chk("sch_i_ready", bus.sch_i_ready, !busy && !bus.flush_pulse);
    chk("fmis_i_valid", bus.fmis_i_valid, m_req);
    chk("fmis_o_ready", bus.fmis_o_ready, m_req | m_owed);
    chk("sch_o_valid", bus.sch_o_valid, m_res);
    chk("sch_busy", bus.sch_busy, busy);
    if (busy) begin
      chk("fmis_i_rs1", bus.fmis_i_rs1, op_rs1);
      chk("fmis_i_rs2", bus.fmis_i_rs2, op_rs2);
      chk("fmis_i_imm", bus.fmis_i_imm, op_imm);
      chk("fmis_i_info", bus.fmis_i_info, op_info);
      chk("fmis_i_itag", bus.fmis_i_itag, op_itag);
    end
    if (m_res) begin
      chk("sch_o_wdat", bus.sch_o_wdat, res_wdat);
      chk("sch_o_err", bus.sch_o_err, res_err);
      chk("sch_o_itag", bus.sch_o_itag, op_itag);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit f, ir, ov, busy, acc;
    bit n_req, n_owed, n_disc, n_res;
    f = bus.flush_pulse; ir = bus.fmis_i_ready; ov = bus.fmis_o_valid;
    busy = m_req | m_owed | m_res;
    acc = !busy && !f && bus.sch_i_valid;
    n_req = m_req; n_owed = m_owed; n_disc = m_disc; n_res = m_res;
    if (acc) begin
      n_req = 1;
      op_rs1 = bus.sch_i_rs1; op_rs2 = bus.sch_i_rs2; op_imm = bus.sch_i_imm;
      op_info = bus.sch_i_info; op_itag = bus.sch_i_itag;
    end
    if (m_req) begin
      if (ir) begin
        n_req = 0;
        if (ov) begin
          if (!f) begin
            n_res = 1; res_wdat = bus.fmis_o_wbck_wdat; res_err = bus.fmis_o_wbck_err;
          end
        end else begin
          n_owed = 1; n_disc = f;
        end
      end else if (f) begin
        n_req = 0;
      end
    end
    if (m_owed) begin
      if (ov) begin
        n_owed = 0; n_disc = 0;
        if (!m_disc && !f) begin
          n_res = 1; res_wdat = bus.fmis_o_wbck_wdat; res_err = bus.fmis_o_wbck_err;
        end
      end else if (f) begin
        n_disc = 1;
      end
    end
    if (m_res && (f || bus.sch_o_ready)) n_res = 0;
    m_req = n_req; m_owed = n_owed; m_disc = n_disc; m_res = n_res;
  endtask

  initial begin
    model_reset();
    drive_random();
    #1;
    check_all_zero();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i != 0) @(negedge clk);
      drive_random();
      #1;
      if (i % 700 == 350) begin
        // Reset lands asynchronously, mid-cycle, whatever the op is doing.
        rst_n = 1'b0;
        #1;
        check_all_zero();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_random();
        #1;
      end
      check_outputs();
      model_step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
